// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel registered mux, fixed-select or round-robin
// arbitration, valid/ready handshakes on every input and on the output.
module rr_mux_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic [WIDTH-1:0] chan [NCH];
    logic             load;
    logic             fix_hit;
    logic             rr_hit;
    logic             hit;
    logic             take;
    logic [SELW-1:0]  rr_g;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  g;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            chan[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Register is free when empty or being drained on this edge.
    assign load = !out_valid || out_ready;

    assign fix_hit = (32'(sel) < NCH) && in_valid[sel];

    // Scan from the far end back to ptr so the last hit is the first in order.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        cand   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = SELW'((int'(ptr) + i) % NCH);
            if (in_valid[cand]) begin
                rr_hit = 1'b1;
                rr_g   = cand;
            end
        end
    end

    assign hit  = mode ? rr_hit : fix_hit;
    assign g    = mode ? rr_g : sel;
    assign take = !rst && load && hit;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[g] = 1'b1;
        end
    end

    assign ptr_nxt = (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= chan[g];
            out_ch    <= g;
            if (mode) begin
                ptr <= ptr_nxt;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed vector table on a 4-channel instance plus random
// traffic on 4- and 3-channel instances against a behavioural model.
module tb_rr_mux_reg;

    localparam int W0 = 8;
    localparam int N0 = 4;
    localparam int W1 = 5;
    localparam int N1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mode;

    logic [1:0]  sel0;
    logic [31:0] in_data0;
    logic [3:0]  in_valid0;
    logic [3:0]  in_ready0;
    logic [7:0]  out_data0;
    logic        out_valid0;
    logic        out_ready0;
    logic [1:0]  out_ch0;

    logic [1:0]  sel1;
    logic [14:0] in_data1;
    logic [2:0]  in_valid1;
    logic [2:0]  in_ready1;
    logic [4:0]  out_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [1:0]  out_ch1;

    rr_mux_reg #(.WIDTH(W0), .NCH(N0)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel0),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_ch(out_ch0)
    );

    rr_mux_reg #(.WIDTH(W1), .NCH(N1)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_ch(out_ch1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic [7:0] dat;
    } vec_t;

    localparam int NT = 32;
    vec_t tv [NT];

    function automatic vec_t mk(logic r, logic m, logic [1:0] s,
                                logic [3:0] v, logic o, logic [3:0] y,
                                logic ov, logic [1:0] c, logic [7:0] d);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o;
        t.rdy = y; t.ov = ov; t.ch = c; t.dat = d;
        return t;
    endfunction

    // Behavioural model: one entry per instance.
    int          mv [2];
    int          md [2];
    int          mc [2];
    int          mp [2];
    int          m_sel [2];
    logic [31:0] m_vb [2];
    logic        m_ordy [2];
    logic [31:0] m_dat [2];

    function automatic int grant_of(int nch, logic m, int s,
                                    logic [31:0] vb, int p);
        if (!m) begin
            if (s < nch && vb[s]) return s;
            return -1;
        end
        for (int i = 0; i < nch; i++) begin
            int k;
            k = (p + i) % nch;
            if (vb[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_grant(input int d, input int nch,
                               output int g, output logic [31:0] rdy);
        g = grant_of(nch, mode, m_sel[d], m_vb[d], mp[d]);
        if (rst || !(mv[d] == 0 || m_ordy[d])) g = -1;
        rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    endtask

    task automatic model_clock(input int d, input int nch, input int w,
                               input int g);
        if (rst) begin
            mv[d] = 0; md[d] = 0; mc[d] = 0; mp[d] = 0;
        end else if (g >= 0) begin
            mv[d] = 1;
            md[d] = int'((m_dat[d] >> (g * w)) & ((32'd1 << w) - 1));
            mc[d] = g;
            if (mode) mp[d] = (g + 1) % nch;
        end else if (mv[d] != 0 && m_ordy[d]) begin
            mv[d] = 0;
        end
    endtask

    initial begin
        int          g0;
        int          g1;
        logic [31:0] r0;
        logic [31:0] r1;

        // reset with all valid, then round-robin 0..3 twice
        tv[0]  = mk(1, 1, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0, 8'h00);
        tv[1]  = mk(1, 1, 2'd0, 4'b1111, 1, 4'b0000, 0, 2'd0, 8'h00);
        tv[2]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h11);
        tv[3]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 8'h22);
        tv[4]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h33);
        tv[5]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 8'h44);
        tv[6]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h11);
        tv[7]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 8'h22);
        tv[8]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h33);
        tv[9]  = mk(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 8'h44);
        // skipping idle channels
        tv[10] = mk(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 8'h22);
        tv[11] = mk(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 8'h44);
        tv[12] = mk(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 2'd1, 8'h22);
        tv[13] = mk(0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 2'd3, 8'h44);
        // ptr to 3, then wrap to ch0, ptr becomes 1
        tv[14] = mk(0, 1, 2'd0, 4'b0100, 1, 4'b0100, 1, 2'd2, 8'h33);
        tv[15] = mk(0, 1, 2'd0, 4'b0001, 1, 4'b0001, 1, 2'd0, 8'h11);
        tv[16] = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 8'h22);
        // backpressure for 3 cycles, then drain and load together
        tv[17] = mk(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h22);
        tv[18] = mk(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h22);
        tv[19] = mk(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h22);
        tv[20] = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h33);
        // fixed mode
        tv[21] = mk(0, 0, 2'd2, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h33);
        tv[22] = mk(0, 0, 2'd2, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h33);
        tv[23] = mk(0, 0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 8'h33);
        tv[24] = mk(0, 0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 8'h33);
        tv[25] = mk(0, 0, 2'd3, 4'b1111, 0, 4'b1000, 1, 2'd3, 8'h44);
        tv[26] = mk(0, 0, 2'd3, 4'b1111, 0, 4'b0000, 1, 2'd3, 8'h44);
        // back to rr: ptr left at 3 by fixed mode
        tv[27] = mk(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 8'h44);
        tv[28] = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h11);
        // reset mid-stream with a held word and ptr=1
        tv[29] = mk(0, 1, 2'd0, 4'b1111, 0, 4'b0000, 1, 2'd0, 8'h11);
        tv[30] = mk(1, 1, 2'd0, 4'b1111, 0, 4'b0000, 0, 2'd0, 8'h00);
        tv[31] = mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h11);

        in_data0   = {8'h44, 8'h33, 8'h22, 8'h11};
        sel1       = 2'd0;
        in_data1   = '0;
        in_valid1  = '0;
        out_ready1 = 1'b1;

        for (int i = 0; i < NT; i++) begin
            rst        = tv[i].rst;
            mode       = tv[i].mode;
            sel0       = tv[i].sel;
            in_valid0  = tv[i].vld;
            out_ready0 = tv[i].ordy;
            #1;
            chk($sformatf("t%0d in_ready", i), 32'(in_ready0), 32'(tv[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("t%0d out_valid", i), 32'(out_valid0), 32'(tv[i].ov));
            chk($sformatf("t%0d out_ch", i), 32'(out_ch0), 32'(tv[i].ch));
            chk($sformatf("t%0d out_data", i), 32'(out_data0), 32'(tv[i].dat));
        end

        for (int n = 0; n < 3000; n++) begin
            rst = (n < 2) || ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            for (int d = 0; d < 2; d++) begin
                m_sel[d]  = int'($urandom_range(0, 3));
                m_vb[d]   = $urandom;
                m_ordy[d] = ($urandom_range(0, 3) != 0);
                m_dat[d]  = $urandom;
            end
            sel0       = 2'(m_sel[0]);
            in_valid0  = m_vb[0][3:0];
            out_ready0 = m_ordy[0];
            in_data0   = m_dat[0];
            sel1       = 2'(m_sel[1]);
            in_valid1  = m_vb[1][2:0];
            out_ready1 = m_ordy[1];
            in_data1   = m_dat[1][14:0];
            #1;
            model_grant(0, N0, g0, r0);
            model_grant(1, N1, g1, r1);
            chk("rnd4 in_ready", 32'(in_ready0), r0);
            chk("rnd3 in_ready", 32'(in_ready1), r1);
            @(posedge clk);
            #1;
            model_clock(0, N0, W0, g0);
            model_clock(1, N1, W1, g1);
            chk("rnd4 out_valid", 32'(out_valid0), 32'(mv[0]));
            chk("rnd4 out_ch", 32'(out_ch0), 32'(mc[0]));
            chk("rnd4 out_data", 32'(out_data0), 32'(md[0]));
            chk("rnd3 out_valid", 32'(out_valid1), 32'(mv[1]));
            chk("rnd3 out_ch", 32'(out_ch1), 32'(mc[1]));
            chk("rnd3 out_data", 32'(out_data1), 32'(md[1]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
